rect_sum: RTL and testbench

Consumes the corner-address stream of the rectangle address generator (four addresses per rectangle, order A, B, D, C, `eot` on C), reads the window integral-image buffer at each address and accumulates the signed combination A − B + D − C. It emits one rectangle pixel-sum per `eot`-terminated group to the feature-evaluation stage through a valid/ready register. It sits between the rectangle address generator and the feature weighting/threshold logic.

---
 rtl/rect_sum_if.sv | 39 +++
 rtl/rect_sum.sv | 139 +++++++++++++
 tb/tb_rect_sum.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_sum_if.sv
// rect_sum_if: groups the three handshake/bus paths of the rectangle summer.
//   - corner address stream from the rectangle address generator
//     (addr_valid / addr_ready / addr_data / addr_eot)
//   - integral-image buffer read port
//     (mem_rd_en / mem_rd_addr / mem_rd_data, data one cycle after the strobe)
//   - rectangle sum output towards feature evaluation
//     (sum_valid / sum_ready / sum_data, signed two's complement)
// Modports:
//   slave  - the rect_sum block itself
//   master - the surrounding environment (generator, buffer, consumer)
interface rect_sum_if #(
  parameter int W_ADDR = 10,
  parameter int W_DATA = 18
);
  localparam int W_SUM = W_DATA + 2;

  logic              addr_valid;
  logic              addr_ready;
  logic [W_ADDR-1:0] addr_data;
  logic              addr_eot;

  logic              mem_rd_en;
  logic [W_ADDR-1:0] mem_rd_addr;
  logic [W_DATA-1:0] mem_rd_data;

  logic              sum_valid;
  logic              sum_ready;
  logic [W_SUM-1:0]  sum_data;

  modport slave (
    input  addr_valid, addr_data, addr_eot, mem_rd_data, sum_ready,
    output addr_ready, mem_rd_en, mem_rd_addr, sum_valid, sum_data
  );

  modport master (
    output addr_valid, addr_data, addr_eot, mem_rd_data, sum_ready,
    input  addr_ready, mem_rd_en, mem_rd_addr, sum_valid, sum_data
  );
endinterface

// File: rtl/rect_sum.sv
// rect_sum: turns the A, B, D, C corner-address stream of the rectangle
// address generator into one rectangle pixel-sum (A - B + D - C) per
// eot-terminated group. Each accepted corner is forwarded combinationally as
// an integral-buffer read; the returned word is folded into a signed
// accumulator one cycle later, and the group total is handed downstream
// through a valid/ready output register.
//
// Ports:
//   clk  - single clock
//   rst  - synchronous, active-high reset
//   bus  - rect_sum_if.slave: corner stream in, buffer read port, sum out
//   err  - sticky group-length error
//
// Build option: define RECT_SUM_CHECK_EN to build the group-length checker
// (err goes high when eot arrives on a term other than C, or C arrives
// without eot). Without it err is tied low; the datapath is unchanged.
module rect_sum #(
  parameter int W_DATA = 18
) (
  input  logic      clk,
  input  logic      rst,
  rect_sum_if.slave bus,
  output logic      err
);
  localparam int W_SUM = W_DATA + 2;

  logic [1:0]       idx_q, idx_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_eot_q, pend_eot_d;
  logic             pend_sub_q, pend_sub_d;
  logic [W_SUM-1:0] acc_q, acc_d;
  logic [W_SUM-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;

  logic             addr_ready;
  logic             accept;
  logic [W_SUM-1:0] term;
  logic [W_SUM-1:0] acc_next;

  // The final corner may only enter when its result will have a free output
  // slot two cycles later: the register is empty or draining now, and no
  // earlier group is about to load it. Other corners never stall.
  always_comb begin
    addr_ready = ~rst & (~bus.addr_eot |
                         ((~sum_valid_q | bus.sum_ready) & ~pend_eot_q));
    accept     = bus.addr_valid & addr_ready;
  end

  assign bus.addr_ready  = addr_ready;
  assign bus.mem_rd_en   = accept;
  assign bus.mem_rd_addr = bus.addr_data;
  assign bus.sum_valid   = sum_valid_q;
  assign bus.sum_data    = sum_q;

  // The accumulator is always zero at the first term of a group (cleared on
  // every group end and by reset), so the first-term base needs no extra
  // flag. Arithmetic wraps modulo 2^W_SUM.
  always_comb begin
    term     = {{(W_SUM-W_DATA){1'b0}}, bus.mem_rd_data};
    acc_next = pend_sub_q ? (acc_q - term) : (acc_q + term);
  end

  // Next-state logic: term counter and read tag on accept, accumulation one
  // cycle later, and the output register where a new load overrides a
  // handshake in the same cycle so back-to-back results leave no bubble.
  always_comb begin
    idx_d       = idx_q;
    pend_vld_d  = accept;
    pend_eot_d  = accept & bus.addr_eot;
    pend_sub_d  = accept & idx_q[0];
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;

    if (accept) begin
      idx_d = bus.addr_eot ? 2'd0 : idx_q + 2'd1;
    end

    if (sum_valid_q & bus.sum_ready) begin
      sum_valid_d = 1'b0;
    end

    if (pend_vld_q) begin
      if (pend_eot_q) begin
        sum_d       = acc_next;
        sum_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_next;
      end
    end
  end

  // State registers; reset drops any in-flight read and partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= 2'd0;
      pend_vld_q  <= 1'b0;
      pend_eot_q  <= 1'b0;
      pend_sub_q  <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      pend_vld_q  <= pend_vld_d;
      pend_eot_q  <= pend_eot_d;
      pend_sub_q  <= pend_sub_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

`ifdef RECT_SUM_CHECK_EN
  logic err_q, err_d;

  // A group is well formed only if eot coincides with the fourth term.
  always_comb begin
    err_d = err_q;
    if (accept & (bus.addr_eot != (idx_q == 2'd3))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rect_sum.sv
// tb_rect_sum: directed bench for rect_sum. A small integral-buffer model
// answers reads one cycle late; a reference model accumulates each accepted
// group with plain signed arithmetic and predicts when each sum must appear,
// and a monitor compares sum_valid / sum_data / err against it every cycle.
// Directed sequences add hand-computed literal expectations.
module tb_rect_sum;
  localparam int W_ADDR = 10;
  localparam int W_DATA = 18;
  localparam int W_SUM  = W_DATA + 2;

`ifdef RECT_SUM_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic err;

  rect_sum_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus();

  rect_sum #(.W_DATA(W_DATA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  logic [W_DATA-1:0] ii [1024];

  // Integral-image buffer: registered read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ii[bus.mem_rd_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model and per-cycle monitor.
  typedef struct {
    logic [W_SUM-1:0] val;
    int               due;
  } exp_t;

  exp_t             exp_q[$];
  int               cyc = 0;
  int               grp_k = 0;
  logic [W_SUM-1:0] grp_sum = '0;
  logic [W_SUM-1:0] term_m;
  bit               err_m = 1'b0;
  bit               exp_valid;
  int               hs_cnt = 0;
  int               hs_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      checkOutput("mon_sum_valid", bus.sum_valid, exp_valid);
      if (exp_valid) checkOutput("mon_sum_data", bus.sum_data, exp_q[0].val);
      checkOutput("mon_err", err, err_m);
      #4;
      if (rst) begin
        exp_q.delete();
        grp_k   = 0;
        grp_sum = '0;
        err_m   = 1'b0;
      end else begin
        if (bus.sum_valid && bus.sum_ready) begin
          hs_cnt++;
          hs_cyc.push_back(cyc);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (bus.addr_valid && bus.addr_ready) begin
          term_m = W_SUM'(ii[bus.addr_data]);
          if (ERR_EN && ((bus.addr_eot && (grp_k % 4) != 3) ||
                         (!bus.addr_eot && (grp_k % 4) == 3))) err_m = 1'b1;
          grp_sum = ((grp_k % 2) == 0) ? grp_sum + term_m : grp_sum - term_m;
          grp_k++;
          if (bus.addr_eot) begin
            exp_q.push_back('{grp_sum, cyc + 2});
            grp_k   = 0;
            grp_sum = '0;
          end
        end
      end
    end
  end

  // Offer one corner, holding it until accepted (bounded).
  task automatic applyStimulus(input logic [W_ADDR-1:0] a, input logic e);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      bus.addr_valid = 1'b1;
      bus.addr_data  = a;
      bus.addr_eot   = e;
      #4;
      if (bus.addr_ready) begin
        checkOutput("rd_en", bus.mem_rd_en, 1);
        checkOutput("rd_addr", bus.mem_rd_addr, a);
        done = 1'b1;
      end else begin
        stall_cnt++;
        waited++;
        if (waited > 40) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: addr 0x%0h never accepted, required within 40 cycles", a);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1 bus.addr_valid = 1'b0;
  endtask

  task automatic sendRect(input logic [W_ADDR-1:0] a, input logic [W_ADDR-1:0] b,
                          input logic [W_ADDR-1:0] d, input logic [W_ADDR-1:0] c);
    applyStimulus(a, 1'b0);
    applyStimulus(b, 1'b0);
    applyStimulus(d, 1'b0);
    applyStimulus(c, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.addr_valid = 1'b0;
    end
  endtask

  task automatic waitSum(input string name, input logic [W_SUM-1:0] expected);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.sum_valid) begin
        checkOutput(name, bus.sum_data, expected);
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no sum_valid within 10 cycles, required 0x%0h", name, expected);
    end
  endtask

  int stall0, hs0;

  initial begin
    foreach (ii[i]) ii[i] = '0;
    ii[78]  = 18'd12;
    ii[10]  = 18'd5;     ii[11]  = 18'd7;      ii[20]  = 18'd30;    ii[21]  = 18'd8;
    ii[100] = 18'd1000;  ii[101] = 18'd200;    ii[102] = 18'd300;   ii[103] = 18'd50;
    ii[200] = 18'd262143; ii[201] = 18'd100000; ii[202] = 18'd50000; ii[203] = 18'd12;
    ii[300] = 18'd9;     ii[301] = 18'd4;      ii[302] = 18'd7;     ii[303] = 18'd1;
    ii[310] = 18'd100;   ii[311] = 18'd1;      ii[312] = 18'd1;     ii[313] = 18'd50;
    ii[401] = 18'd262143;
    ii[500] = 18'd1000;  ii[501] = 18'd1;
    ii[510] = 18'd40;    ii[511] = 18'd10;     ii[512] = 18'd20;    ii[513] = 18'd5;
    ii[600] = 18'd5;     ii[601] = 18'd2;      ii[602] = 18'd4;

    rst            = 1'b1;
    bus.sum_ready  = 1'b1;
    bus.addr_valid = 1'b1;
    bus.addr_eot   = 1'b0;
    bus.addr_data  = '0;

    // Reset state: non-eot corner offered, yet nothing accepted during rst.
    @(negedge clk);
    #4;
    checkOutput("rst_addr_ready", bus.addr_ready, 0);
    checkOutput("rst_rd_en", bus.mem_rd_en, 0);
    @(negedge clk);
    checkOutput("rst_sum_valid", bus.sum_valid, 0);
    checkOutput("rst_sum_data", bus.sum_data, 0);
    checkOutput("rst_err", err, 0);
    rst            = 1'b0;
    bus.addr_valid = 1'b0;
    idle(2);

    // Single rectangle: 0 - 0 + 12 - 0, valid exactly two cycles after C.
    sendRect(10'd0, 10'd3, 10'd78, 10'd75);
    @(negedge clk);
    checkOutput("lat_t1_valid", bus.sum_valid, 0);
    @(negedge clk);
    checkOutput("lat_t2_valid", bus.sum_valid, 1);
    checkOutput("single_sum", bus.sum_data, 12);
    idle(3);

    // Three back-to-back rectangles with the consumer always ready.
    stall0 = stall_cnt;
    hs0    = hs_cnt;
    sendRect(10'd10, 10'd11, 10'd20, 10'd21);     // 20
    sendRect(10'd100, 10'd101, 10'd102, 10'd103); // 1050
    sendRect(10'd200, 10'd201, 10'd202, 10'd203); // 212131
    idle(4);
    checkOutput("b2b_no_stall", stall_cnt - stall0, 0);
    checkOutput("b2b_count", hs_cnt - hs0, 3);
    checkOutput("b2b_gap1", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], 4);
    checkOutput("b2b_gap2", hs_cyc[hs_cyc.size()-2] - hs_cyc[hs_cyc.size()-3], 4);

    // Back-pressure: first sum held, second rect's C stalled until release.
    @(negedge clk);
    bus.sum_ready = 1'b0;
    hs0 = hs_cnt;
    sendRect(10'd300, 10'd301, 10'd302, 10'd303); // 11
    stall0 = stall_cnt;
    applyStimulus(10'd310, 1'b0);
    applyStimulus(10'd311, 1'b0);
    applyStimulus(10'd312, 1'b0);
    checkOutput("bp_abd_no_stall", stall_cnt - stall0, 0);
    fork
      applyStimulus(10'd313, 1'b1);
      begin
        repeat (10) @(negedge clk);
        checkOutput("bp_held_valid", bus.sum_valid, 1);
        checkOutput("bp_held_data", bus.sum_data, 11);
        bus.sum_ready = 1'b1;
      end
    join
    checkOutput("bp_c_stalled", (stall_cnt - stall0) >= 5, 1);
    @(negedge clk);
    checkOutput("bp_gap_valid", bus.sum_valid, 0);
    waitSum("bp_second_sum", 20'd50);
    idle(3);
    checkOutput("bp_delivered", hs_cnt - hs0, 2);

    // Wrap: 0 - (2^18-1) + 0 - 0 in 20-bit two's complement.
    sendRect(10'd400, 10'd401, 10'd402, 10'd403);
    waitSum("wrap_sum", 20'hC0001);
    idle(3);

    // Reset after B: partial group discarded, next group clean.
    applyStimulus(10'd500, 1'b0);
    applyStimulus(10'd501, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_mid_no_sum", bus.sum_valid, 0);
    end
    sendRect(10'd510, 10'd511, 10'd512, 10'd513);
    waitSum("post_rst_sum", 20'd45);
    idle(3);

    // Short group: eot on the third corner; sum still emitted.
    applyStimulus(10'd600, 1'b0);
    applyStimulus(10'd601, 1'b0);
    applyStimulus(10'd602, 1'b1);
    waitSum("short_sum", 20'd7);
    @(negedge clk);
    checkOutput("err_set", err, ERR_EN);
    sendRect(10'd610, 10'd611, 10'd612, 10'd613);
    waitSum("after_err_sum", 20'd0);
    @(negedge clk);
    checkOutput("err_sticky", err, ERR_EN);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", err, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
